// File: rtl/multi_player_controller.sv
// Turn-based game controller: serves, scores and lives for up to eight players
// sharing one playfield, with a timed hold between turns.
module multi_player_controller #(
  parameter int NUM_PLAYERS = 2,
  parameter int LIVES_INIT  = 3,
  parameter int LIVES_MAX   = 7,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int BAD_PENALTY = 1,
  parameter int HOLD_CYCLES = 25000000,
  localparam int unsigned PLAYER_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic               key5IsPressed,
  input  logic               collisionBallObstacleGood,
  input  logic               collisionBallObstacleBad,
  input  logic               collisionBallBottom,
  input  logic               collisionBallCredit,
  input  logic [SCORE_W-1:0] scoreNumber,
  output logic               pause,
  output logic               reset_level,
  output logic               reset_level_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         life,
  output logic [PLAYER_W-1:0] player,
  output logic               gameOver,
  output logic               win
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, HOLD, GAME_OVER, WIN} state_t;

  state_t               state;
  logic [SCORE_W-1:0]   scores [NUM_PLAYERS];
  logic [3:0]           lives  [NUM_PLAYERS];
  logic [CNT_W-1:0]     holdCnt;
  logic                 advance;
  logic                 creditUsed;

  logic startQ, key5Q, goodQ, badQ, bottomQ, creditQ;
  logic startEdge, key5Edge, goodEdge, badEdge, bottomEdge, creditEdge;

  assign startEdge  = start & ~startQ;
  assign key5Edge   = key5IsPressed & ~key5Q;
  assign goodEdge   = collisionBallObstacleGood & ~goodQ;
  assign badEdge    = collisionBallObstacleBad & ~badQ;
  assign bottomEdge = collisionBallBottom & ~bottomQ;
  assign creditEdge = collisionBallCredit & ~creditQ;

  logic [SCORE_W-1:0]  curScore, scoreAdd, scoreSub;
  logic [SCORE_W:0]    scoreSum;
  logic [3:0]          curLife, lifeDec, lifeInc;
  logic                anyWin, allDead, found;
  logic [PLAYER_W-1:0] cand, nextPlayer;

  // Per-player arithmetic and the turn-advance search
  always_comb begin
    curScore   = scores[player];
    curLife    = lives[player];
    scoreSum   = {1'b0, curScore} + {1'b0, scoreNumber};
    scoreAdd   = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
    scoreSub   = (curScore >= SCORE_W'(BAD_PENALTY)) ? curScore - SCORE_W'(BAD_PENALTY) : '0;
    lifeDec    = (curLife == 4'd0) ? 4'd0 : curLife - 4'd1;
    lifeInc    = (curLife >= 4'(LIVES_MAX)) ? curLife : curLife + 4'd1;
    anyWin     = 1'b0;
    allDead    = 1'b1;
    found      = 1'b0;
    cand       = '0;
    nextPlayer = player;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (scores[PLAYER_W'(i)] >= SCORE_W'(WIN_SCORE)) anyWin = 1'b1;
      if (lives[PLAYER_W'(i)] != 4'd0) allDead = 1'b0;
    end
    for (int i = 1; i <= NUM_PLAYERS; i++) begin
      cand = PLAYER_W'((int'(player) + i) % NUM_PLAYERS);
      if (!found && lives[cand] != 4'd0) begin
        nextPlayer = cand;
        found      = 1'b1;
      end
    end
    if (NUM_PLAYERS == 1) nextPlayer = '0;
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state             <= IDLE;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        scores[i] <= '0;
        lives[i]  <= 4'(LIVES_INIT);
      end
      player            <= '0;
      holdCnt           <= '0;
      advance           <= 1'b0;
      creditUsed        <= 1'b0;
      // Track live inputs during reset so a level already high at release is not an edge
      startQ            <= start;
      key5Q             <= key5IsPressed;
      goodQ             <= collisionBallObstacleGood;
      badQ              <= collisionBallObstacleBad;
      bottomQ           <= collisionBallBottom;
      creditQ           <= collisionBallCredit;
      pause             <= 1'b1;
      reset_level       <= 1'b1;
      reset_level_pulse <= 1'b0;
      gameOver          <= 1'b0;
      win               <= 1'b0;
      score             <= '0;
      life              <= 4'(LIVES_INIT);
    end else begin
      startQ            <= start;
      key5Q             <= key5IsPressed;
      goodQ             <= collisionBallObstacleGood;
      badQ              <= collisionBallObstacleBad;
      bottomQ           <= collisionBallBottom;
      creditQ           <= collisionBallCredit;
      reset_level_pulse <= 1'b0;

      case (state)
        IDLE, GAME_OVER, WIN: begin
          if (startEdge) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              scores[i] <= '0;
              lives[i]  <= 4'(LIVES_INIT);
            end
            player            <= '0;
            advance           <= 1'b0;
            creditUsed        <= 1'b0;
            score             <= '0;
            life              <= 4'(LIVES_INIT);
            gameOver          <= 1'b0;
            win               <= 1'b0;
            pause             <= 1'b0;
            reset_level       <= 1'b1;
            reset_level_pulse <= 1'b1;
            state             <= SERVE;
          end
        end

        SERVE: begin
          if (key5Edge) begin
            reset_level <= 1'b0;
            state       <= PLAY;
          end
        end

        // One event per cycle, bottom first; the rest of that cycle's edges are dropped
        PLAY: begin
          if (bottomEdge) begin
            lives[player] <= lifeDec;
            life          <= lifeDec;
            advance       <= 1'b1;
            holdCnt       <= CNT_W'(HOLD_CYCLES - 1);
            pause         <= 1'b1;
            reset_level   <= 1'b1;
            state         <= HOLD;
          end else if (goodEdge) begin
            scores[player] <= scoreAdd;
            score          <= scoreAdd;
            advance        <= 1'b0;
            holdCnt        <= CNT_W'(HOLD_CYCLES - 1);
            pause          <= 1'b1;
            reset_level    <= 1'b1;
            state          <= HOLD;
          end else if (badEdge) begin
            scores[player] <= scoreSub;
            score          <= scoreSub;
            advance        <= 1'b0;
            holdCnt        <= CNT_W'(HOLD_CYCLES - 1);
            pause          <= 1'b1;
            reset_level    <= 1'b1;
            state          <= HOLD;
          end else if (creditEdge && !creditUsed) begin
            lives[player] <= lifeInc;
            life          <= lifeInc;
            creditUsed    <= 1'b1;
          end
        end

        HOLD: begin
          if (holdCnt != '0) begin
            holdCnt <= holdCnt - CNT_W'(1);
          end else if (anyWin) begin
            win   <= 1'b1;
            state <= WIN;
          end else if (allDead) begin
            gameOver <= 1'b1;
            state    <= GAME_OVER;
          end else begin
            if (advance) begin
              player <= nextPlayer;
              score  <= scores[nextPlayer];
              life   <= lives[nextPlayer];
            end
            creditUsed        <= 1'b0;
            pause             <= 1'b0;
            reset_level_pulse <= 1'b1;
            state             <= SERVE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_player_controller.sv
// Scoreboard bench for multi_player_controller: a small game model predicts
// score/life/player after each event and each turn change.
module tb_multi_player_controller;

  localparam int NP    = 2;
  localparam int HOLD  = 4;
  localparam int LINIT = 3;
  localparam int LMAX  = 7;
  localparam int WINS  = 9;
  localparam int SMAX  = 15;

  localparam int K_BOTTOM = 0, K_GOOD = 1, K_BAD = 2, K_CREDIT = 3, K_BOTH = 4;
  localparam int O_SERVE = 0, O_WIN = 1, O_OVER = 2;

  logic       clk = 1'b0;
  logic       resetN, start, key5IsPressed;
  logic       good, bad, bottom, credit;
  logic [3:0] scoreNumber;
  logic       pause, reset_level, reset_level_pulse, gameOver, win;
  logic [3:0] score, life;
  logic [0:0] player;

  multi_player_controller #(
    .NUM_PLAYERS(NP), .LIVES_INIT(LINIT), .LIVES_MAX(LMAX), .SCORE_W(4),
    .WIN_SCORE(WINS), .BAD_PENALTY(1), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .resetN(resetN), .start(start), .key5IsPressed(key5IsPressed),
    .collisionBallObstacleGood(good), .collisionBallObstacleBad(bad),
    .collisionBallBottom(bottom), .collisionBallCredit(credit),
    .scoreNumber(scoreNumber), .pause(pause), .reset_level(reset_level),
    .reset_level_pulse(reset_level_pulse), .score(score), .life(life),
    .player(player), .gameOver(gameOver), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int life;
    int player;
  } exp_t;

  exp_t sbQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  int mScore [NP];
  int mLife  [NP];
  int mPlayer;
  bit mAdv;
  bit mCreditUsed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input int got, input int exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pushExp();
    exp_t e;
    e.score  = mScore[mPlayer];
    e.life   = mLife[mPlayer];
    e.player = mPlayer;
    sbQ.push_back(e);
  endtask

  task automatic checkScoreboard(input string tag);
    exp_t e;
    checkVal({tag, ".sbDepth"}, sbQ.size(), 1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal({tag, ".score"},  int'(score),  e.score);
      checkVal({tag, ".life"},   int'(life),   e.life);
      checkVal({tag, ".player"}, int'(player), e.player);
    end
  endtask

  task automatic mStart();
    for (int i = 0; i < NP; i++) begin
      mScore[i] = 0;
      mLife[i]  = LINIT;
    end
    mPlayer = 0;
    mAdv = 1'b0;
    mCreditUsed = 1'b0;
  endtask

  task automatic mServe();
    mCreditUsed = 1'b0;
    if (mAdv) begin
      for (int k = 1; k <= NP; k++) begin
        int c;
        c = (mPlayer + k) % NP;
        if (mLife[c] > 0) begin
          mPlayer = c;
          break;
        end
      end
    end
  endtask

  function automatic int modelOutcome();
    bit dead;
    dead = 1'b1;
    for (int i = 0; i < NP; i++) if (mScore[i] >= WINS) return O_WIN;
    for (int i = 0; i < NP; i++) if (mLife[i] > 0) dead = 1'b0;
    return dead ? O_OVER : O_SERVE;
  endfunction

  task automatic checkIdle(input string tag);
    checkVal({tag, ".pause"},      int'(pause), 1);
    checkVal({tag, ".resetLevel"}, int'(reset_level), 1);
    checkVal({tag, ".pulse"},      int'(reset_level_pulse), 0);
    checkVal({tag, ".gameOver"},   int'(gameOver), 0);
    checkVal({tag, ".win"},        int'(win), 0);
    checkVal({tag, ".score"},      int'(score), 0);
    checkVal({tag, ".life"},       int'(life), LINIT);
    checkVal({tag, ".player"},     int'(player), 0);
  endtask

  task automatic startGame(input string tag);
    start = 1'b1;
    mStart();
    pushExp();
    tick();
    start = 1'b0;
    checkVal({tag, ".pulse"},      int'(reset_level_pulse), 1);
    checkVal({tag, ".resetLevel"}, int'(reset_level), 1);
    checkVal({tag, ".pause"},      int'(pause), 0);
    checkVal({tag, ".gameOver"},   int'(gameOver), 0);
    checkVal({tag, ".win"},        int'(win), 0);
    checkScoreboard(tag);
  endtask

  // Called right after SERVE entry: strobe must already be gone, then key5 launches
  task automatic launch();
    tick();
    checkVal("serve.pulseOneCycle", int'(reset_level_pulse), 0);
    key5IsPressed = 1'b1;
    tick();
    key5IsPressed = 1'b0;
    checkVal("play.resetLevel", int'(reset_level), 0);
    checkVal("play.pause", int'(pause), 0);
  endtask

  task automatic doHit(input int kind);
    string tag;
    case (kind)
      K_BOTTOM: begin
        bottom = 1'b1; tag = "bottom";
        if (mLife[mPlayer] > 0) mLife[mPlayer]--;
        mAdv = 1'b1;
      end
      K_BOTH: begin
        bottom = 1'b1; good = 1'b1; tag = "bottomGood";
        if (mLife[mPlayer] > 0) mLife[mPlayer]--;
        mAdv = 1'b1;
      end
      K_GOOD: begin
        good = 1'b1; tag = "good";
        mScore[mPlayer] = (mScore[mPlayer] + int'(scoreNumber) > SMAX) ? SMAX
                          : mScore[mPlayer] + int'(scoreNumber);
        mAdv = 1'b0;
      end
      K_BAD: begin
        bad = 1'b1; tag = "bad";
        if (mScore[mPlayer] > 0) mScore[mPlayer]--;
        mAdv = 1'b0;
      end
      default: begin
        credit = 1'b1; tag = "credit";
        if (!mCreditUsed) begin
          if (mLife[mPlayer] < LMAX) mLife[mPlayer]++;
          mCreditUsed = 1'b1;
        end
      end
    endcase
    pushExp();
    tick();
    checkScoreboard(tag);
    checkVal({tag, ".pause"}, int'(pause), (kind == K_CREDIT) ? 0 : 1);
    bottom = 1'b0; good = 1'b0; bad = 1'b0; credit = 1'b0;
    tick();
  endtask

  // doHit leaves us two cycles into HOLD, so HOLD-1 more ticks reach the exit
  task automatic finishHold(input string tag, output int oc);
    int n;
    n = 0;
    while (!(reset_level_pulse || win || gameOver) && n < 40) begin
      tick();
      n++;
    end
    checkVal({tag, ".holdLen"}, n, HOLD - 1);
    oc = modelOutcome();
    checkVal({tag, ".pulse"},    int'(reset_level_pulse), (oc == O_SERVE) ? 1 : 0);
    checkVal({tag, ".win"},      int'(win),               (oc == O_WIN)   ? 1 : 0);
    checkVal({tag, ".gameOver"}, int'(gameOver),          (oc == O_OVER)  ? 1 : 0);
    checkVal({tag, ".pause"},    int'(pause),             (oc == O_SERVE) ? 0 : 1);
    if (oc == O_SERVE) begin
      mServe();
      pushExp();
      checkScoreboard({tag, ".serve"});
    end else if (oc == O_WIN) begin
      checkVal({tag, ".winScore"}, int'(score), mScore[mPlayer]);
    end else begin
      checkVal({tag, ".overLife"}, int'(life), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int oc, guard;
    resetN = 1'b1; start = 1'b1; key5IsPressed = 1'b0;
    good = 1'b0; bad = 1'b0; bottom = 1'b1; credit = 1'b0;
    scoreNumber = 4'd5;
    repeat (3) tick();
    checkIdle("reset");
    bottom = 1'b0;
    resetN = 1'b0;
    repeat (2) tick();
    checkIdle("releaseStartHigh");
    start = 1'b0;
    tick();

    // First turn: bottom hands the serve to player 1
    startGame("start");
    launch();
    doHit(K_BOTTOM);
    finishHold("turn1", oc);

    // Simultaneous bottom + good: only the bottom counts
    launch();
    doHit(K_BOTH);
    finishHold("turn2", oc);

    // Bad at score 0 floors, player keeps the serve
    launch();
    doHit(K_BAD);
    finishHold("badFloor", oc);

    // Credits: once per serve, climbing to the ceiling
    launch();
    doHit(K_CREDIT);
    doHit(K_CREDIT);
    doHit(K_BAD);
    finishHold("credit0", oc);
    for (int r = 0; r < 4; r++) begin
      launch();
      doHit(K_CREDIT);
      doHit(K_BAD);
      finishHold("creditLoop", oc);
    end
    launch();
    credit = 1'b1;
    if (!mCreditUsed) begin
      if (mLife[mPlayer] < LMAX) mLife[mPlayer]++;
      mCreditUsed = 1'b1;
    end
    pushExp();
    repeat (10) tick();
    checkScoreboard("creditHeld");
    credit = 1'b0;
    tick();

    // Two good hits of 5 reach 10 and win
    doHit(K_GOOD);
    finishHold("good1", oc);
    launch();
    doHit(K_GOOD);
    finishHold("good2", oc);
    repeat (5) tick();
    checkVal("win.held", int'(win), 1);

    // Restart, then lose every life; player 1 runs out first
    startGame("restartFromWin");
    launch();
    doHit(K_CREDIT);
    doHit(K_GOOD);
    finishHold("preGo", oc);
    launch();
    doHit(K_CREDIT);
    guard = 0;
    do begin
      doHit(K_BOTTOM);
      finishHold("lives", oc);
      if (oc == O_SERVE) launch();
      guard++;
    end while (oc == O_SERVE && guard < 20);
    checkVal("gameOver.reached", oc, O_OVER);
    repeat (3) tick();
    checkVal("gameOver.held", int'(gameOver), 1);
    startGame("restartFromOver");

    // Reset in the middle of a hold count
    launch();
    doHit(K_BOTTOM);
    resetN = 1'b1;
    tick();
    resetN = 1'b0;
    checkIdle("resetMidHold");
    tick();
    checkIdle("afterResetMidHold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
